// File: rtl/poly_pkg.sv
// Shared encodings for the polynomial sequencer and its datapath:
// FSM states, ALU opcodes and ALU operand-mux selects.
package poly_pkg;

    typedef enum logic [3:0] {
        S_LOAD_A = 4'd0,
        S_LOAD_B = 4'd1,
        S_LOAD_C = 4'd2,
        S_LOAD_X = 4'd3,
        S_H0     = 4'd4,
        S_H1     = 4'd5,
        S_H2     = 4'd6,
        S_H3     = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

    localparam logic [1:0] SEL_A = 2'd0;
    localparam logic [1:0] SEL_B = 2'd1;
    localparam logic [1:0] SEL_C = 2'd2;
    localparam logic [1:0] SEL_X = 2'd3;

endpackage

// File: rtl/poly_sequencer_edge_sync.sv
// Synchroniser for an asynchronous button input followed by a rising-edge
// detector; produces one clk-wide pulse per press however long it is held.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
            hist   <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist;

endmodule

// File: rtl/poly_sequencer.sv
// Control FSM computing r = A*x^2 + B*x + C on the shared-ALU datapath via
// Horner's method, with edge-qualified operand capture, abort and status.
module poly_sequencer
    import poly_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       go,
    input  logic       abort,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_c,
    output logic       ld_x,
    output logic       ld_r,
    output logic       ld_alu_out,
    output logic [1:0] alu_select_a,
    output logic [1:0] alu_select_b,
    output logic       alu_op,
    output logic [1:0] operand_idx,
    output logic       busy,
    output logic       done
);

    state_t state, next_state;
    logic   go_rise;
    logic   la, lb, lc, lx, lr;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_go_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (go),
        .rise   (go_rise)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_LOAD_A;
        else         state <= next_state;
    end

    always_comb begin
        next_state   = state;
        la           = 1'b0;
        lb           = 1'b0;
        lc           = 1'b0;
        lx           = 1'b0;
        lr           = 1'b0;
        ld_alu_out   = 1'b0;
        alu_select_a = SEL_A;
        alu_select_b = SEL_A;
        alu_op       = ALU_ADD;
        operand_idx  = 2'd0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state)
            S_LOAD_A: begin
                la = go_rise;
                if (go_rise) next_state = S_LOAD_B;
            end
            S_LOAD_B: begin
                operand_idx = 2'd1;
                lb          = go_rise;
                if (go_rise) next_state = S_LOAD_C;
            end
            S_LOAD_C: begin
                operand_idx = 2'd2;
                lc          = go_rise;
                if (go_rise) next_state = S_LOAD_X;
            end
            S_LOAD_X: begin
                operand_idx = 2'd3;
                lx          = go_rise;
                if (go_rise) next_state = S_H0;
            end
            S_H0, S_H2: begin
                busy         = 1'b1;
                ld_alu_out   = 1'b1;
                alu_select_b = SEL_X;
                alu_op       = ALU_MUL;
                la           = 1'b1;
                next_state   = (state == S_H0) ? S_H1 : S_H3;
            end
            S_H1: begin
                busy         = 1'b1;
                ld_alu_out   = 1'b1;
                alu_select_b = SEL_B;
                la           = 1'b1;
                next_state   = S_H2;
            end
            S_H3: begin
                busy         = 1'b1;
                ld_alu_out   = 1'b1;
                alu_select_b = SEL_C;
                lr           = 1'b1;
                next_state   = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (go_rise) next_state = S_LOAD_A;
            end
            default: next_state = S_LOAD_A;
        endcase
        // Abort wins over everything: suppress every register write this cycle.
        if (abort) begin
            next_state = S_LOAD_A;
            la         = 1'b0;
            lb         = 1'b0;
            lc         = 1'b0;
            lx         = 1'b0;
            lr         = 1'b0;
        end
    end

    assign ld_a = la;
    assign ld_b = lb;
    assign ld_c = lc;
    assign ld_x = lx;
    assign ld_r = lr;

endmodule

// File: tb/tb_poly_sequencer.sv
// Bench for poly_sequencer: drives it with a small 8-bit datapath and checks
// results against A*x^2 + B*x + C mod 256 plus the timing and control rules.
module tb_poly_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic       ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out, alu_op, busy, done;
    logic [1:0] alu_select_a, alu_select_b, operand_idx;

    logic [7:0] sw = 8'd0;
    logic [7:0] dp_a, dp_b, dp_c, dp_x, dp_r, alu_in_a, alu_in_b, alu_out;

    int checks = 0;
    int failures = 0;
    int cnt_a = 0, cnt_b = 0, cnt_c = 0, cnt_x = 0, cnt_r = 0;

    always #5 clk = ~clk;

    poly_sequencer #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .go           (go),
        .abort        (abort),
        .ld_a         (ld_a),
        .ld_b         (ld_b),
        .ld_c         (ld_c),
        .ld_x         (ld_x),
        .ld_r         (ld_r),
        .ld_alu_out   (ld_alu_out),
        .alu_select_a (alu_select_a),
        .alu_select_b (alu_select_b),
        .alu_op       (alu_op),
        .operand_idx  (operand_idx),
        .busy         (busy),
        .done         (done)
    );

    function automatic logic [7:0] pick(input logic [1:0] sel, input logic [7:0] a, b, c, x);
        case (sel)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return c;
            default: return x;
        endcase
    endfunction

    // Team datapath: 8-bit registers around a shared add/multiply ALU.
    always_comb begin
        alu_in_a = pick(alu_select_a, dp_a, dp_b, dp_c, dp_x);
        alu_in_b = pick(alu_select_b, dp_a, dp_b, dp_c, dp_x);
        alu_out  = alu_op ? 8'(alu_in_a * alu_in_b) : 8'(alu_in_a + alu_in_b);
    end

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dp_a <= 8'd0; dp_b <= 8'd0; dp_c <= 8'd0; dp_x <= 8'd0; dp_r <= 8'd0;
        end else begin
            if (ld_a) dp_a <= ld_alu_out ? alu_out : sw;
            if (ld_b) dp_b <= ld_alu_out ? alu_out : sw;
            if (ld_c) dp_c <= sw;
            if (ld_x) dp_x <= sw;
            if (ld_r) dp_r <= alu_out;
        end
    end

    always @(posedge clk) begin
        if (resetn) begin
            if (ld_a) cnt_a <= cnt_a + 1;
            if (ld_b) cnt_b <= cnt_b + 1;
            if (ld_c) cnt_c <= cnt_c + 1;
            if (ld_x) cnt_x <= cnt_x + 1;
            if (ld_r) cnt_r <= cnt_r + 1;
        end
    end

    function automatic logic [7:0] poly_ref(input int a, b, c, x);
        int v;
        v = a * x * x + b * x + c;
        return 8'(v % 256);
    endfunction

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Press go and wait (bounded) for exactly the expected operand load pulse.
    task automatic press_load(input logic [7:0] val, input logic [3:0] exp_ld, input string tag);
        bit found = 0;
        @(negedge clk);
        sw = val;
        go = 1'b1;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            #1;
            if ({ld_a, ld_b, ld_c, ld_x} != 4'b0000) begin
                found = 1;
                check_output({tag, "_ld"}, {28'd0, ld_a, ld_b, ld_c, ld_x}, {28'd0, exp_ld});
            end
        end
        if (!found) check_output({tag, "_timeout"}, 0, 1);
        go = 1'b0;
    endtask

    task automatic run_compute(input logic [7:0] exp_r, input bit press_mid, input string tag);
        int a0 = cnt_a, b0 = cnt_b, c0 = cnt_c, x0 = cnt_x, r0 = cnt_r;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_output({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
            if (press_mid && i == 1) go = 1'b1;
        end
        @(negedge clk);
        #1;
        check_output({tag, "_done"}, {30'd0, busy, done}, 32'd1);
        check_output({tag, "_r"}, dp_r, exp_r);
        check_output({tag, "_cnt"}, {cnt_a - a0, cnt_b - b0, cnt_c - c0, cnt_x - x0, cnt_r - r0},
                     {3, 0, 0, 0, 1});
        if (press_mid) begin
            settle(3);
            #1;
            check_output({tag, "_stay_done"}, {31'd0, done}, 32'd1);
            check_output({tag, "_r_kept"}, dp_r, exp_r);
            go = 1'b0;
            settle(3);
        end
    endtask

    task automatic load_operands(input logic [7:0] a, b, c, x, input string tag);
        #1 check_output({tag, "_idx0"}, operand_idx, 0);
        press_load(a, 4'b1000, {tag, "_a"}); settle(3);
        #1 check_output({tag, "_idx1"}, operand_idx, 1);
        press_load(b, 4'b0100, {tag, "_b"}); settle(3);
        #1 check_output({tag, "_idx2"}, operand_idx, 2);
        press_load(c, 4'b0010, {tag, "_c"}); settle(3);
        #1 check_output({tag, "_idx3"}, operand_idx, 3);
        press_load(x, 4'b0001, {tag, "_x"});
    endtask

    task automatic apply_stimulus(input logic [7:0] a, b, c, x, input string tag);
        load_operands(a, b, c, x, tag);
        run_compute(poly_ref(a, b, c, x), 1'b0, tag);
    endtask

    // Leave S_DONE: the press must return to operand A without loading anything.
    task automatic press_done(input string tag);
        bit left = 0;
        int a0 = cnt_a;
        @(negedge clk);
        go = 1'b1;
        for (int i = 0; i < 8 && !left; i++) begin
            @(negedge clk);
            #1;
            if (!done) left = 1;
        end
        check_output({tag, "_left_done"}, {31'd0, left}, 1);
        check_output({tag, "_idx_after"}, {operand_idx, busy}, 0);
        go = 1'b0;
        settle(3);
        check_output({tag, "_no_load"}, cnt_a - a0, 0);
    endtask

    function automatic logic [31:0] all_outputs();
        return {17'd0, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out, alu_select_a, alu_select_b,
                alu_op, operand_idx, busy, done};
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] ra, rb, rc, rx;
        int a0;

        #12;
        check_output("reset_outputs", all_outputs(), 0);
        @(negedge clk);
        resetn = 1'b1;
        settle(2);

        apply_stimulus(8'd2, 8'd3, 8'd4, 8'd5, "basic");
        check_output("basic_0x45", dp_r, 32'h45);
        press_done("basic");

        apply_stimulus(8'h10, 8'h00, 8'h01, 8'h10, "ovf");
        check_output("ovf_0x01", dp_r, 32'h01);
        press_done("ovf");

        // Held button: a 50-cycle press must give exactly one A load.
        a0 = cnt_a;
        @(negedge clk);
        sw = 8'd7;
        go = 1'b1;
        settle(50);
        #1;
        check_output("held_one_pulse", cnt_a - a0, 1);
        check_output("held_idx", operand_idx, 1);
        go = 1'b0;
        settle(3);
        #1 check_output("held_idx_stays", operand_idx, 1);
        press_load(8'd1, 4'b0100, "held_b"); settle(3);
        press_load(8'd2, 4'b0010, "held_c"); settle(3);
        press_load(8'd3, 4'b0001, "held_x");
        run_compute(poly_ref(7, 1, 2, 3), 1'b1, "ignored");
        press_done("ignored");

        // Abort asserted across the go_rise cycle in S_LOAD_C.
        press_load(8'd9, 4'b1000, "abort_a"); settle(3);
        press_load(8'd9, 4'b0100, "abort_b"); settle(3);
        a0 = cnt_c;
        @(negedge clk);
        sw = 8'd9;
        go = 1'b1;
        abort = 1'b1;
        settle(4);
        abort = 1'b0;
        go = 1'b0;
        #1;
        check_output("abort_no_ldc", cnt_c - a0, 0);
        check_output("abort_idx", operand_idx, 0);
        settle(3);
        apply_stimulus(8'd1, 8'd1, 8'd1, 8'd2, "rerun");
        check_output("rerun_0x07", dp_r, 32'h07);
        press_done("rerun");

        for (int n = 0; n < 5; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rx = 8'($urandom);
            apply_stimulus(ra, rb, rc, rx, "rand");
            press_done("rand");
        end

        // Asynchronous reset in S_H2, between clock edges.
        load_operands(8'd3, 8'd4, 8'd5, 8'd6, "arst");
        settle(3);
        #1 check_output("arst_in_h2", {31'd0, busy}, 1);
        #2 resetn = 1'b0;
        #1 check_output("arst_outputs", all_outputs(), 0);
        @(negedge clk);
        resetn = 1'b1;
        settle(2);
        apply_stimulus(8'd5, 8'd6, 8'd7, 8'd8, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
